alu_op_sequencer: RTL and testbench

Multi-cycle instruction sequencer that owns the 16-bit ALU and its flag register. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives the ALU one-hot `alu_sel` and operands, writes the result back, and merges the ALU flags into a 5-bit flag register using per-opcode update masks. It sits between the instruction source and the combinational ALU.

---
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Instruction/ALU bus between the sequencer and its environment.
// The slave side is the sequencer: it takes instructions and ALU results, and drives ALU operands and completions.
// The master side is the instruction source together with the combinational ALU.
// Signals: instr_* handshake and fields, alu_a/alu_b/alu_sel out to the ALU,
//          alu_out/alu_flcnz back from the ALU, done_valid/done_err completion.
interface alu_op_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic [7:0]  instr_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [5:0]  alu_sel;
    logic [15:0] alu_out;
    logic [4:0]  alu_flcnz;
    logic        done_valid;
    logic        done_err;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output alu_out, alu_flcnz,
        input  instr_ready, alu_a, alu_b, alu_sel, done_valid, done_err
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  alu_out, alu_flcnz,
        output instr_ready, alu_a, alu_b, alu_sel, done_valid, done_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Serial instruction sequencer that owns the ALU operands, an 8x16 register file and the {F,L,C,N,Z} flags.
// Latency: ALU ops complete EXEC_CYCLES+1 cycles after accept, and LDI or illegal ops 1 cycle after accept.
// Backpressure: instr_ready is low from accept until the cycle after done_valid, and completions cannot be stalled.
// Ports: CLK, RESETn (async active-low); bus (slave modport: instr handshake, ALU bus, done);
//        flags, dbg_addr/dbg_data (combinational register read); perf_ops/perf_err when ALU_SEQ_PERF_EN is defined.
module alu_op_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                RESETn,
    alu_op_sequencer_if.slave   bus,
    output logic [4:0]          flags,
    input  logic [2:0]          dbg_addr,
    output logic [15:0]         dbg_data
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]         perf_ops,
    output logic [7:0]          perf_err
`endif
);
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_CMP = 3'd2,
                           OP_LDI = 3'd6, OP_ILL = 3'd7;

    typedef enum logic [1:0] {IDLE, OPER, EXEC, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_op, r_rd, r_rs1, r_rs2;
    logic [7:0]  r_imm;
    logic [3:0]  r_cnt;
    logic [15:0] r_alu_a, r_alu_b;
    logic [5:0]  r_alu_sel;
    logic [4:0]  r_flags;
    logic [15:0] r_regs [0:7];

    logic        w_instr_ready, w_done_valid, w_done_err;
    logic        w_is_alu, w_is_sub;
    logic [5:0]  w_sel_dec;

    assign w_is_alu = (r_op <= 3'd5);
    // SUB and CMP feed the inverted operand: the ALU adds carry-in 1 to complete the two's complement.
    assign w_is_sub = (r_op == OP_SUB) || (r_op == OP_CMP);

    always_comb begin
        w_sel_dec = 6'b000000;
        case (r_op)
            3'd0:    w_sel_dec = 6'b100000;
            3'd1:    w_sel_dec = 6'b010000;
            3'd2:    w_sel_dec = 6'b001000;
            3'd3:    w_sel_dec = 6'b000100;
            3'd4:    w_sel_dec = 6'b000010;
            3'd5:    w_sel_dec = 6'b000001;
            default: w_sel_dec = 6'b000000;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_instr_ready = 1'b0;
        w_done_valid  = 1'b0;
        w_done_err    = 1'b0;
        case (r_state)
            IDLE: begin
                w_instr_ready = 1'b1;
                if (bus.instr_valid) w_state_nxt = OPER;
            end
            OPER:    w_state_nxt = w_is_alu ? EXEC : RESP;
            EXEC:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP: begin
                w_done_valid = 1'b1;
                w_done_err   = (r_op == OP_ILL);
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_op      <= 3'd0;
            r_rd      <= 3'd0;
            r_rs1     <= 3'd0;
            r_rs2     <= 3'd0;
            r_imm     <= 8'd0;
            r_cnt     <= 4'd0;
            r_alu_a   <= 16'd0;
            r_alu_b   <= 16'd0;
            r_alu_sel <= 6'd0;
            r_flags   <= 5'd0;
            for (int i = 0; i < 8; i++) r_regs[i] <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        r_op  <= bus.instr_op;
                        r_rd  <= bus.instr_rd;
                        r_rs1 <= bus.instr_rs1;
                        r_rs2 <= bus.instr_rs2;
                        r_imm <= bus.instr_imm;
                    end
                end
                OPER: begin
                    if (w_is_alu) begin
                        r_alu_a   <= r_regs[r_rs1];
                        r_alu_b   <= w_is_sub ? ~r_regs[r_rs2] : r_regs[r_rs2];
                        r_alu_sel <= w_sel_dec;
                        r_cnt     <= CNT_INIT;
                    end else if (r_op == OP_LDI) begin
                        r_regs[r_rd] <= {8'h00, r_imm};
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        if (r_op != OP_CMP) r_regs[r_rd] <= bus.alu_out;
                        // Each opcode class owns a fixed subset of the flags; the rest hold.
                        if (r_op == OP_ADD || r_op == OP_SUB) begin
                            r_flags[4] <= bus.alu_flcnz[4];
                            r_flags[2] <= bus.alu_flcnz[2];
                        end else if (r_op == OP_CMP) begin
                            r_flags[3] <= bus.alu_flcnz[3];
                            r_flags[1] <= bus.alu_flcnz[1];
                            r_flags[0] <= bus.alu_flcnz[0];
                        end
                        r_alu_sel <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] r_perf_ops;
    logic [7:0]  r_perf_err;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_perf_ops <= 16'd0;
            r_perf_err <= 8'd0;
        end else if (w_done_valid) begin
            if (w_done_err) begin
                if (r_perf_err != 8'hFF) r_perf_err <= r_perf_err + 8'd1;
            end else begin
                if (r_perf_ops != 16'hFFFF) r_perf_ops <= r_perf_ops + 16'd1;
            end
        end
    end

    assign perf_ops = r_perf_ops;
    assign perf_err = r_perf_err;
`endif

    assign bus.instr_ready = w_instr_ready;
    assign bus.done_valid  = w_done_valid;
    assign bus.done_err    = w_done_err;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_sel     = r_alu_sel;
    assign flags           = r_flags;
    assign dbg_data        = r_regs[dbg_addr];
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    localparam int EC = 4;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [4:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops;
    logic [7:0]  perf_err;
`endif
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_op_sequencer_if ifc();

    alu_op_sequencer #(.EXEC_CYCLES(EC)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .bus      (ifc.slave),
        .flags    (flags),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_ops (perf_ops),
        .perf_err (perf_err)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference ALU: SUB/CMP add carry-in 1; L is unsigned borrow, F is signed overflow.
    logic [16:0] m_sum;
    logic [15:0] m_res;
    logic [4:0]  m_fl;
    logic        m_sub, m_arith;
    always_comb begin
        m_sub   = ifc.alu_sel[4] | ifc.alu_sel[3];
        m_arith = ifc.alu_sel[5] | m_sub;
        m_sum   = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + {16'd0, m_sub};
        m_res   = 16'h0000;
        if (m_arith)             m_res = m_sum[15:0];
        else if (ifc.alu_sel[2]) m_res = ifc.alu_a & ifc.alu_b;
        else if (ifc.alu_sel[1]) m_res = ifc.alu_a | ifc.alu_b;
        else if (ifc.alu_sel[0]) m_res = ifc.alu_a ^ ifc.alu_b;
        m_fl[0] = (m_res == 16'h0000);
        m_fl[1] = m_res[15];
        m_fl[2] = m_arith & m_sum[16];
        m_fl[3] = m_sub & ~m_sum[16];
        m_fl[4] = m_arith & (ifc.alu_a[15] == ifc.alu_b[15]) & (m_res[15] != ifc.alu_a[15]);
    end
    assign ifc.alu_out   = m_res;
    assign ifc.alu_flcnz = m_fl;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one instruction and follows it to completion, recording what was observed.
    task automatic run_instr(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm,
                             output int lat, output int sel_cyc, output logic [5:0] sel_seen,
                             output logic [15:0] a_seen, output logic [15:0] b_seen,
                             output logic err_seen, output logic extra_done);
        int  acc;
        bit  got;
        lat = -1; sel_cyc = 0; sel_seen = 6'd0; a_seen = 16'd0; b_seen = 16'd0;
        err_seen = 1'b0; extra_done = 1'b0; got = 0; acc = -1;
        @(negedge CLK);
        ifc.instr_op = op; ifc.instr_rd = rd; ifc.instr_rs1 = rs1;
        ifc.instr_rs2 = rs2; ifc.instr_imm = imm; ifc.instr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (ifc.instr_ready) begin acc = cyc + 1; break; end
            @(negedge CLK);
        end
        if (acc < 0) begin
            total++; bad++; ifc.instr_valid = 1'b0;
            $display("FAIL accept_timeout: op=%0d never accepted", op);
            return;
        end
        @(posedge CLK); #1 ifc.instr_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (ifc.done_valid) begin
                lat = cyc - acc; err_seen = ifc.done_err; got = 1; break;
            end
            if (ifc.alu_sel != 6'd0) begin
                sel_cyc++; sel_seen = ifc.alu_sel; a_seen = ifc.alu_a; b_seen = ifc.alu_b;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL done_timeout: op=%0d no done_valid", op);
        end
        @(negedge CLK);
        extra_done = ifc.done_valid;
    endtask

    task automatic test_reset();
        RESETn = 1'b0; ifc.instr_valid = 1'b0; ifc.instr_op = 3'd0; ifc.instr_rd = 3'd0;
        ifc.instr_rs1 = 3'd0; ifc.instr_rs2 = 3'd0; ifc.instr_imm = 8'd0; dbg_addr = 3'd0;
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        total++; if (ifc.instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ifc.instr_ready); end
        total++; if (ifc.alu_sel !== 6'd0) begin bad++; $display("FAIL rst_sel: got %b want 000000", ifc.alu_sel); end
        total++; if ({ifc.alu_a, ifc.alu_b} !== 32'd0) begin bad++; $display("FAIL rst_ab: got %h want 0", {ifc.alu_a, ifc.alu_b}); end
        total++; if ({ifc.done_valid, ifc.done_err} !== 2'b00) begin bad++; $display("FAIL rst_done: got %b want 00", {ifc.done_valid, ifc.done_err}); end
        total++; if (flags !== 5'd0) begin bad++; $display("FAIL rst_flags: got %b want 00000", flags); end
        total++; if (dbg_data !== 16'd0) begin bad++; $display("FAIL rst_r0: got %h want 0000", dbg_data); end
    endtask

    task automatic test_ldi_add();
        int lat, sc; logic [5:0] s; logic [15:0] a, b; logic e, x;
        run_instr(3'd6, 3'd1, 3'd0, 3'd0, 8'h05, lat, sc, s, a, b, e, x);
        total++; if (lat !== 1) begin bad++; $display("FAIL ldi_latency: got %0d want 1", lat); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ldi_err: got %b want 0", e); end
        run_instr(3'd6, 3'd2, 3'd0, 3'd0, 8'h03, lat, sc, s, a, b, e, x);
        dbg_addr = 3'd1; #1;
        total++; if (dbg_data !== 16'h0005) begin bad++; $display("FAIL ldi_r1: got %h want 0005", dbg_data); end
        dbg_addr = 3'd2; #1;
        total++; if (dbg_data !== 16'h0003) begin bad++; $display("FAIL ldi_r2: got %h want 0003", dbg_data); end
        run_instr(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, lat, sc, s, a, b, e, x);
        total++; if (sc !== EC) begin bad++; $display("FAIL add_sel_cycles: got %0d want %0d", sc, EC); end
        total++; if (s !== 6'b100000) begin bad++; $display("FAIL add_sel: got %b want 100000", s); end
        total++; if ({a, b} !== {16'h0005, 16'h0003}) begin bad++; $display("FAIL add_ab: got %h/%h want 0005/0003", a, b); end
        total++; if (lat !== EC + 1) begin bad++; $display("FAIL add_latency: got %0d want %0d", lat, EC + 1); end
        total++; if (x !== 1'b0) begin bad++; $display("FAIL add_done_pulse: done still high"); end
        dbg_addr = 3'd3; #1;
        total++; if (dbg_data !== 16'h0008) begin bad++; $display("FAIL add_r3: got %h want 0008", dbg_data); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL add_flags: got %b want 00000", flags); end
    endtask

    task automatic test_sub();
        int lat, sc; logic [5:0] s; logic [15:0] a, b; logic e, x;
        run_instr(3'd1, 3'd4, 3'd2, 3'd1, 8'h00, lat, sc, s, a, b, e, x);
        total++; if (s !== 6'b010000) begin bad++; $display("FAIL sub_sel: got %b want 010000", s); end
        total++; if (b !== 16'hFFFA) begin bad++; $display("FAIL sub_b: got %h want fffa", b); end
        dbg_addr = 3'd4; #1;
        total++; if (dbg_data !== 16'hFFFE) begin bad++; $display("FAIL sub_r4: got %h want fffe", dbg_data); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL sub_flags_borrow: got %b want 00000", flags); end
        run_instr(3'd1, 3'd5, 3'd1, 3'd2, 8'h00, lat, sc, s, a, b, e, x);
        dbg_addr = 3'd5; #1;
        total++; if (dbg_data !== 16'h0002) begin bad++; $display("FAIL sub_r5: got %h want 0002", dbg_data); end
        total++; if (flags !== 5'b00100) begin bad++; $display("FAIL sub_flags_carry: got %b want 00100", flags); end
    endtask

    task automatic test_cmp();
        int lat, sc; logic [5:0] s; logic [15:0] a, b; logic e, x;
        run_instr(3'd2, 3'd6, 3'd1, 3'd1, 8'h00, lat, sc, s, a, b, e, x);
        total++; if (s !== 6'b001000) begin bad++; $display("FAIL cmp_sel: got %b want 001000", s); end
        total++; if (flags !== 5'b00101) begin bad++; $display("FAIL cmp_eq_flags: got %b want 00101", flags); end
        dbg_addr = 3'd6; #1;
        total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL cmp_no_write: got %h want 0000", dbg_data); end
        run_instr(3'd2, 3'd6, 3'd2, 3'd1, 8'h00, lat, sc, s, a, b, e, x);
        total++; if (flags !== 5'b01110) begin bad++; $display("FAIL cmp_lt_flags: got %b want 01110", flags); end
        dbg_addr = 3'd1; #1;
        total++; if (dbg_data !== 16'h0005) begin bad++; $display("FAIL cmp_r1_kept: got %h want 0005", dbg_data); end
    endtask

    task automatic test_logic();
        int lat, sc; logic [5:0] s; logic [15:0] a, b; logic e, x;
        run_instr(3'd4, 3'd7, 3'd1, 3'd2, 8'h00, lat, sc, s, a, b, e, x);
        total++; if (s !== 6'b000010) begin bad++; $display("FAIL or_sel: got %b want 000010", s); end
        dbg_addr = 3'd7; #1;
        total++; if (dbg_data !== 16'h0007) begin bad++; $display("FAIL or_r7: got %h want 0007", dbg_data); end
        run_instr(3'd5, 3'd7, 3'd1, 3'd1, 8'h00, lat, sc, s, a, b, e, x);
        total++; if (s !== 6'b000001) begin bad++; $display("FAIL xor_sel: got %b want 000001", s); end
        #1;
        total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL xor_r7: got %h want 0000", dbg_data); end
        total++; if (flags !== 5'b01110) begin bad++; $display("FAIL logic_flags: got %b want 01110", flags); end
    endtask

    task automatic test_illegal();
        int lat, sc; logic [5:0] s; logic [15:0] a, b; logic e, x;
`ifdef ALU_SEQ_PERF_EN
        total++; if (perf_err !== 8'd0) begin bad++; $display("FAIL perf_err_before: got %0d want 0", perf_err); end
`endif
        run_instr(3'd7, 3'd1, 3'd2, 3'd2, 8'hAA, lat, sc, s, a, b, e, x);
        total++; if (lat !== 1) begin bad++; $display("FAIL ill_latency: got %0d want 1", lat); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", e); end
        total++; if (x !== 1'b0) begin bad++; $display("FAIL ill_done_pulse: done still high"); end
        total++; if (sc !== 0) begin bad++; $display("FAIL ill_sel: got %0d active cycles want 0", sc); end
        total++; if ({ifc.alu_a, ifc.alu_b} !== {16'h0005, 16'h0005}) begin bad++; $display("FAIL ill_ab: got %h/%h want 0005/0005", ifc.alu_a, ifc.alu_b); end
        dbg_addr = 3'd1; #1;
        total++; if (dbg_data !== 16'h0005) begin bad++; $display("FAIL ill_r1: got %h want 0005", dbg_data); end
        total++; if (flags !== 5'b01110) begin bad++; $display("FAIL ill_flags: got %b want 01110", flags); end
`ifdef ALU_SEQ_PERF_EN
        total++; if (perf_err !== 8'd1) begin bad++; $display("FAIL perf_err_after: got %0d want 1", perf_err); end
        total++; if (perf_ops !== 16'd9) begin bad++; $display("FAIL perf_ops: got %0d want 9", perf_ops); end
`endif
    endtask

    task automatic test_back_to_back();
        int acc [3];
        logic [2:0] rds [3];
        logic [2:0] s1s [3];
        logic [2:0] s2s [3];
        bit got;
        rds = '{3'd3, 3'd4, 3'd5}; s1s = '{3'd1, 3'd3, 3'd4}; s2s = '{3'd2, 3'd1, 3'd3};
        @(negedge CLK);
        ifc.instr_op = 3'd0; ifc.instr_rd = rds[0]; ifc.instr_rs1 = s1s[0]; ifc.instr_rs2 = s2s[0];
        ifc.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc[i] = -1;
            for (int k = 0; k < 30; k++) begin
                if (ifc.instr_ready) begin acc[i] = cyc + 1; break; end
                @(negedge CLK);
            end
            @(posedge CLK); #1;
            if (i < 2) begin
                ifc.instr_rd = rds[i+1]; ifc.instr_rs1 = s1s[i+1]; ifc.instr_rs2 = s2s[i+1];
            end else begin
                ifc.instr_valid = 1'b0;
            end
            @(negedge CLK);
            total++; if (ifc.instr_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy%0d: ready got %b want 0", i, ifc.instr_ready); end
        end
        got = 0;
        for (int k = 0; k < 30; k++) begin
            if (ifc.done_valid) begin got = 1; break; end
            @(negedge CLK);
        end
        total++; if (!got) begin bad++; $display("FAIL b2b_done: no final done_valid"); end
        total++; if (acc[1] - acc[0] !== EC + 3) begin bad++; $display("FAIL b2b_gap01: got %0d want %0d", acc[1] - acc[0], EC + 3); end
        total++; if (acc[2] - acc[1] !== EC + 3) begin bad++; $display("FAIL b2b_gap12: got %0d want %0d", acc[2] - acc[1], EC + 3); end
        @(negedge CLK);
        dbg_addr = 3'd3; #1;
        total++; if (dbg_data !== 16'h0008) begin bad++; $display("FAIL b2b_r3: got %h want 0008", dbg_data); end
        dbg_addr = 3'd4; #1;
        total++; if (dbg_data !== 16'h000D) begin bad++; $display("FAIL b2b_r4: got %h want 000d", dbg_data); end
        dbg_addr = 3'd5; #1;
        total++; if (dbg_data !== 16'h0015) begin bad++; $display("FAIL b2b_r5: got %h want 0015", dbg_data); end
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL b2b_flags: got %b want 01010", flags); end
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        @(negedge CLK);
        ifc.instr_op = 3'd0; ifc.instr_rd = 3'd6; ifc.instr_rs1 = 3'd1; ifc.instr_rs2 = 3'd2;
        ifc.instr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (ifc.instr_ready) break;
            @(negedge CLK);
        end
        @(posedge CLK); #1 ifc.instr_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        total++; if (ifc.alu_sel !== 6'b100000) begin bad++; $display("FAIL rme_in_exec: sel got %b want 100000", ifc.alu_sel); end
        RESETn = 1'b0; #1;
        total++; if (ifc.alu_sel !== 6'd0) begin bad++; $display("FAIL rme_sel: got %b want 000000", ifc.alu_sel); end
        total++; if (ifc.instr_ready !== 1'b1) begin bad++; $display("FAIL rme_ready: got %b want 1", ifc.instr_ready); end
        total++; if (flags !== 5'd0) begin bad++; $display("FAIL rme_flags: got %b want 00000", flags); end
        @(negedge CLK);
        RESETn = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (ifc.done_valid) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL rme_no_done: done_valid seen after reset"); end
        dbg_addr = 3'd6; #1;
        total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL rme_r6: got %h want 0000", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_sub();
        test_cmp();
        test_logic();
        test_illegal();
        test_back_to_back();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
